// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported memory between instruction fetch (IF) and data access (MEM),
//          one transaction at a time, with a bounded data burst so fetches cannot starve.
// Ports:   clk/rst (async active-low); IF side if_req/if_addr/if_ack/if_rdata/if_stall plus
//          ex_take_branch_out; MEM side d_req/d_we/d_addr/d_wdata/d_ack/d_rdata/d_stall;
//          memory side mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata.
module mem_port_arbiter #(
    parameter int MAX_D_BURST = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        ex_take_branch_out,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_stall,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_stall
);

    localparam int SW = $clog2(MAX_D_BURST + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_BURST);

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    state_t        state_q,  state_d;
    logic [31:0]   addr_q,   addr_d;
    logic          we_q,     we_d;
    logic [31:0]   wdata_q,  wdata_d;
    logic          kill_q,   kill_d;
    logic [SW-1:0] streak_q, streak_d;

    logic grant_d;
    logic grant_f;

    // Byte-offset bits never reach the memory; the bus is word addressed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

    // Data wins a tie unless it already holds the maximum run of grants
    // while a fetch was waiting.
    assign grant_d = d_req & (~if_req | (streak_q != STREAK_MAX));
    assign grant_f = if_req & ~grant_d;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        kill_d   = kill_q;
        streak_d = streak_q;
        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (grant_d) begin
                    state_d = DATA;
                    addr_d  = {d_addr[31:2], 2'b00};
                    we_d    = d_we;
                    wdata_d = d_wdata;
                    // Streak only counts data grants that made a fetch wait.
                    if (if_req) begin
                        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
                    end else begin
                        streak_d = '0;
                    end
                end else if (grant_f) begin
                    state_d  = FETCH;
                    addr_d   = {if_addr[31:2], 2'b00};
                    we_d     = 1'b0;
                    streak_d = '0;
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    kill_d  = 1'b0;
                end else if (ex_take_branch_out) begin
                    // Fetch must still finish on the bus, but its data is stale.
                    kill_d = 1'b1;
                end
            end
            DATA: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                kill_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            kill_q   <= 1'b0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            kill_q   <= kill_d;
            streak_q <= streak_d;
        end
    end

    // Memory-side signals come only from the grant-time registers so they
    // stay stable for the whole transaction regardless of requester inputs.
    assign mem_req   = (state_q != IDLE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_ack   = (state_q == FETCH) & mem_ack & ~kill_q & ~ex_take_branch_out;
    assign if_rdata = mem_rdata;
    assign if_stall = if_req & ~if_ack;

    assign d_ack    = (state_q == DATA) & mem_ack;
    assign d_rdata  = mem_rdata;
    assign d_stall  = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
//          against a transaction-level reference model of the arbitration rules.
// Ports:   none (drives the DUT and plays both requesters and the memory).
module tb_mem_port_arbiter;

    localparam int MAXB = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        ex_take_branch_out = 1'b0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_req, mem_we, if_ack, if_stall, d_ack, d_stall;
    logic [31:0] mem_addr, mem_wdata, if_rdata, d_rdata;

    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter #(.MAX_D_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .ex_take_branch_out(ex_take_branch_out),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall)
    );

    always #5 clk = ~clk;

    // Inputs change just after the rising edge; outputs are sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic test_reset();
        mem_ack = 1'b1;
        settle();
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req got %b want 0", mem_req); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
        vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
        vectors++; if (mem_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); end
        vectors++; if (if_ack !== 1'b0 || d_ack !== 1'b0) begin miscompares++; $display("FAIL rst_acks got %b%b want 00", if_ack, d_ack); end
        tick();
        mem_ack = 1'b0;
        rst = 1'b1;
        if_req = 1'b1;
        if_addr = 32'h10;
        tick();
        settle();
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rst_pre_fetch got %b want 1", mem_req); end
        #1 rst = 1'b0;
        #1;
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_async_drop got %b want 0", mem_req); end
        vectors++; if (if_stall !== 1'b1) begin miscompares++; $display("FAIL rst_if_stall got %b want 1", if_stall); end
        tick();
        if_req = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_ack = 1'b1;
            settle();
            vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_post_req got %b want 0", mem_req); end
            vectors++; if (if_ack !== 1'b0 || d_ack !== 1'b0) begin miscompares++; $display("FAIL rst_post_ack got %b%b want 00", if_ack, d_ack); end
            tick();
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_lone_fetch();
        if_req = 1'b1;
        if_addr = 32'h0000_0006;
        settle();
        vectors++; if (if_stall !== 1'b1 || mem_req !== 1'b0) begin miscompares++; $display("FAIL lone_idle got stall=%b req=%b want 1 0", if_stall, mem_req); end
        tick();
        settle();
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin miscompares++; $display("FAIL lone_grant got req=%b addr=%h want 1 00000004", mem_req, mem_addr); end
        vectors++; if (if_ack !== 1'b0 || if_stall !== 1'b1) begin miscompares++; $display("FAIL lone_wait got ack=%b stall=%b want 0 1", if_ack, if_stall); end
        tick();
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        settle();
        vectors++; if (if_ack !== 1'b1 || if_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL lone_ack got ack=%b data=%h want 1 deadbeef", if_ack, if_rdata); end
        vectors++; if (if_stall !== 1'b0) begin miscompares++; $display("FAIL lone_stall_end got %b want 0", if_stall); end
        tick();
        mem_ack = 1'b0;
        if_req = 1'b0;
        settle();
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL lone_idle_after got %b want 0", mem_req); end
        tick();
    endtask

    task automatic test_contention();
        if_req = 1'b1; if_addr = 32'h0000_0800;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        tick();
        settle();
        vectors++; if (mem_addr !== 32'h100 || mem_we !== 1'b0) begin miscompares++; $display("FAIL cont_data_first got addr=%h we=%b want 00000100 0", mem_addr, mem_we); end
        vectors++; if (if_stall !== 1'b1 || d_stall !== 1'b1) begin miscompares++; $display("FAIL cont_stalls got %b%b want 11", if_stall, d_stall); end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
        settle();
        vectors++; if (d_ack !== 1'b1 || d_rdata !== 32'hCAFE_0001) begin miscompares++; $display("FAIL cont_d_ack got ack=%b data=%h want 1 cafe0001", d_ack, d_rdata); end
        vectors++; if (if_ack !== 1'b0 || if_stall !== 1'b1) begin miscompares++; $display("FAIL cont_if_wait got ack=%b stall=%b want 0 1", if_ack, if_stall); end
        tick();
        mem_ack = 1'b0; d_req = 1'b0;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        settle();
        vectors++; if (mem_addr !== 32'h800 || if_ack !== 1'b1 || if_rdata !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL cont_fetch got addr=%h ack=%b data=%h want 00000800 1 0badf00d", mem_addr, if_ack, if_rdata); end
        tick();
        mem_ack = 1'b0; if_req = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        logic [7:0] want_data;
        want_data = 8'b0111_0111;   // grant k uses bit k: D,D,D,F,D,D,D,F
        if_req = 1'b1; if_addr = 32'h1000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        for (int k = 0; k < 8; k++) begin
            tick();
            mem_ack = 1'b1;
            settle();
            vectors++;
            if (mem_addr !== (want_data[k] ? 32'h2000 : 32'h1000)) begin
                miscompares++;
                $display("FAIL starve_grant%0d got addr=%h want %h", k, mem_addr, want_data[k] ? 32'h2000 : 32'h1000);
            end
            tick();
            mem_ack = 1'b0;
        end
        if_req = 1'b0; d_req = 1'b0;
        tick();
    endtask

    task automatic test_branch_flush();
        if_req = 1'b1; if_addr = 32'h40;
        tick();
        ex_take_branch_out = 1'b1;
        settle();
        vectors++; if (mem_addr !== 32'h40 || if_ack !== 1'b0) begin miscompares++; $display("FAIL br_inflight got addr=%h ack=%b want 00000040 0", mem_addr, if_ack); end
        tick();
        ex_take_branch_out = 1'b0; if_addr = 32'h80;
        settle();
        vectors++; if (mem_addr !== 32'h40) begin miscompares++; $display("FAIL br_addr_hold got %h want 00000040", mem_addr); end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        settle();
        vectors++; if (if_ack !== 1'b0 || if_stall !== 1'b1) begin miscompares++; $display("FAIL br_stale_ack got ack=%b stall=%b want 0 1", if_ack, if_stall); end
        tick();
        mem_ack = 1'b0;
        settle();
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL br_idle got %b want 0", mem_req); end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h3333_4444;
        settle();
        vectors++; if (mem_addr !== 32'h80 || if_ack !== 1'b1 || if_rdata !== 32'h3333_4444) begin miscompares++; $display("FAIL br_refetch got addr=%h ack=%b data=%h want 00000080 1 33334444", mem_addr, if_ack, if_rdata); end
        tick();
        mem_ack = 1'b0; if_addr = 32'hC0;
        tick();
        // Branch arriving with the ack itself suppresses the fetch.
        mem_ack = 1'b1; ex_take_branch_out = 1'b1;
        settle();
        vectors++; if (if_ack !== 1'b0) begin miscompares++; $display("FAIL br_same_cycle got %b want 0", if_ack); end
        tick();
        mem_ack = 1'b0; ex_take_branch_out = 1'b0; if_req = 1'b0;
        settle();
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL br_same_idle got %b want 0", mem_req); end
        tick();
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h1234_5678;
        tick();
        for (int c = 0; c < 3; c++) begin
            mem_ack = (c == 2);
            if (c == 1) d_wdata = 32'hFFFF_0000;   // registered operands must not follow
            settle();
            vectors++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'h1234_5678) begin
                miscompares++;
                $display("FAIL st_bus%0d got req=%b we=%b addr=%h wdata=%h want 1 1 00000200 12345678", c, mem_req, mem_we, mem_addr, mem_wdata);
            end
            vectors++;
            if (d_ack !== (c == 2) || d_stall !== (c != 2)) begin
                miscompares++;
                $display("FAIL st_ack%0d got ack=%b stall=%b want %b %b", c, d_ack, d_stall, c == 2, c != 2);
            end
            tick();
        end
        mem_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
        settle();
        vectors++; if (d_ack !== 1'b0 || d_stall !== 1'b0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL st_after got ack=%b stall=%b req=%b want 0 0 0", d_ack, d_stall, mem_req); end
        tick();
    endtask

    // Randomized run. Reference model works at the transaction level:
    // m_kind 0 = no transaction, 1 = fetch, 2 = data.
    task automatic test_random();
        int          m_kind, m_wait, m_lat, m_streak;
        bit          m_stale, if_pend, d_pend, prev_if_ack, prev_d_ack;
        bit          e_if_ack, e_d_ack;
        logic [31:0] m_addr, m_wdata;
        logic        m_we;
        m_kind = 0; m_wait = 0; m_lat = 0; m_streak = 0; m_stale = 0;
        m_addr = '0; m_wdata = '0; m_we = 1'b0;
        if_pend = 0; d_pend = 0; prev_if_ack = 0; prev_d_ack = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (prev_if_ack) if_pend = 0;
            if (prev_d_ack) d_pend = 0;
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1; if_addr = $urandom;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
            end
            if_req = if_pend;
            d_req = d_pend;
            ex_take_branch_out = ($urandom_range(0, 5) == 0);
            if (ex_take_branch_out && if_pend) if_addr = $urandom;
            if (m_kind != 0) mem_ack = (m_wait >= m_lat);
            else mem_ack = ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
            settle();

            e_if_ack = (m_kind == 1) && mem_ack && !m_stale && !ex_take_branch_out;
            e_d_ack = (m_kind == 2) && mem_ack;
            vectors++; if (mem_req !== (m_kind != 0)) begin miscompares++; $display("FAIL rnd_mem_req cyc%0d got %b want %b", cyc, mem_req, m_kind != 0); end
            vectors++; if (if_ack !== e_if_ack) begin miscompares++; $display("FAIL rnd_if_ack cyc%0d got %b want %b", cyc, if_ack, e_if_ack); end
            vectors++; if (d_ack !== e_d_ack) begin miscompares++; $display("FAIL rnd_d_ack cyc%0d got %b want %b", cyc, d_ack, e_d_ack); end
            vectors++; if (if_stall !== (if_req && !e_if_ack) || d_stall !== (d_req && !e_d_ack)) begin miscompares++; $display("FAIL rnd_stall cyc%0d got %b%b want %b%b", cyc, if_stall, d_stall, if_req && !e_if_ack, d_req && !e_d_ack); end
            if (m_kind != 0) begin
                vectors++; if (mem_addr !== m_addr || mem_we !== m_we) begin miscompares++; $display("FAIL rnd_bus cyc%0d got addr=%h we=%b want %h %b", cyc, mem_addr, mem_we, m_addr, m_we); end
            end
            if (m_kind == 2) begin
                vectors++; if (mem_wdata !== m_wdata) begin miscompares++; $display("FAIL rnd_wdata cyc%0d got %h want %h", cyc, mem_wdata, m_wdata); end
            end
            if (e_if_ack) begin
                vectors++; if (if_rdata !== mem_rdata) begin miscompares++; $display("FAIL rnd_if_rdata cyc%0d got %h want %h", cyc, if_rdata, mem_rdata); end
            end
            if (e_d_ack) begin
                vectors++; if (d_rdata !== mem_rdata) begin miscompares++; $display("FAIL rnd_d_rdata cyc%0d got %h want %h", cyc, d_rdata, mem_rdata); end
            end
            prev_if_ack = e_if_ack;
            prev_d_ack = e_d_ack;

            if (m_kind != 0) begin
                if (mem_ack) begin
                    m_kind = 0; m_stale = 0;
                end else begin
                    m_wait++;
                    if (m_kind == 1 && ex_take_branch_out) m_stale = 1;
                end
            end else if (d_req && (!if_req || m_streak < MAXB)) begin
                m_kind = 2; m_addr = d_addr & 32'hFFFF_FFFC; m_we = d_we; m_wdata = d_wdata;
                m_streak = if_req ? ((m_streak < MAXB) ? m_streak + 1 : MAXB) : 0;
                m_wait = 0; m_lat = $urandom_range(0, 3);
            end else if (if_req) begin
                m_kind = 1; m_addr = if_addr & 32'hFFFF_FFFC; m_we = 1'b0; m_streak = 0;
                m_wait = 0; m_lat = $urandom_range(0, 3);
            end
            tick();
        end
        if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0; ex_take_branch_out = 1'b0;
    endtask

    initial begin
        tick();
        test_reset();
        test_lone_fetch();
        test_contention();
        test_starvation();
        test_branch_flush();
        test_store();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported instruction/data memory between the IF stage (instruction fetch) and the MEM stage (loads/stores). It sequences one memory transaction at a time, stalls the loser via `staller`-style outputs, discards fetch data made stale by a taken branch, and bounds fetch starvation under back-to-back data traffic.

## Interface
- `MAX_D_BURST`, 3: max consecutive data grants allowed while a fetch is waiting.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `if_req`  in  1  IF stage requests an instruction word.
- `if_addr`  in  32  fetch address (PC).
- `ex_take_branch_out`  in  1  taken branch; fetch in flight is stale.
- `d_req`  in  1  MEM stage requests a data access.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  32  data address.
- `d_wdata`  in  32  store data.
- `mem_ack`  in  1  memory completes current transaction (1-cycle pulse; `mem_rdata` valid same cycle).
- `mem_rdata`  in  32  memory read data.
- `mem_req`  out  1  transaction active toward memory.
- `mem_we`  out  1  write enable for active transaction.
- `mem_addr`  out  32  word-aligned address `{addr[31:2],2'b00}`.
- `mem_wdata`  out  32  store data for active transaction.
- `if_ack`  out  1  fetch complete; `if_rdata` valid this cycle.
- `if_rdata`  out  32  instruction word.
- `if_stall`  out  1  `if_req & ~if_ack`; drives IF `staller`.
- `d_ack`  out  1  data access complete; `d_rdata` valid this cycle.
- `d_rdata`  out  32  load data.
- `d_stall`  out  1  `d_req & ~d_ack`.

## Operation
- FSM states: IDLE, FETCH, DATA.
- IDLE: choose winner from `if_req`/`d_req` sampled this cycle.
  - only `if_req` -> FETCH; only `d_req` -> DATA; neither -> stay.
  - both: DATA unless `d_streak == MAX_D_BURST`, then FETCH.
- On grant, latch address (and `d_we`, `d_wdata` for DATA) into registers; `mem_*` outputs come from these registers only, stable for the whole transaction.
- FETCH/DATA: `mem_req = 1` until `mem_ack`; on `mem_ack` -> IDLE.
- `if_ack = (state==FETCH) & mem_ack & ~kill & ~ex_take_branch_out`; `if_rdata = mem_rdata`.
- `d_ack = (state==DATA) & mem_ack`; `d_rdata = mem_rdata` (don't-care for stores).
- `kill` flag: set when `ex_take_branch_out` is high in FETCH without `mem_ack`; cleared on leaving FETCH. Stale fetch completes on the bus but is never acked; IF re-requests with new PC.
- `ex_take_branch_out` in IDLE or DATA: no effect.
- `d_streak` (width clog2(MAX_D_BURST+1)): on DATA grant with `if_req` high, increments, saturating at `MAX_D_BURST`; on FETCH grant, cleared; on DATA grant with `if_req` low, cleared.
- Requesters must hold `*_req` and operands until their ack; dropping a request mid-transaction does not abort it (result discarded by requester).

## Timing
- Reset (asynchronous, immediate): state IDLE, `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `kill=0`, `d_streak=0`; `if_ack=d_ack=0`; stalls follow requests combinationally. An in-flight memory transaction is abandoned.
- Request seen in IDLE at cycle N -> `mem_req` high cycle N+1 -> earliest ack cycle N+1 (combinational memory) -> IDLE at N+2. Peak throughput one transaction per 2 cycles.
- Longer memory latency: `mem_req` held, requester stalled, until `mem_ack`.
- `mem_ack` outside FETCH/DATA is ignored.
- Branch and `mem_ack` in same cycle: fetch suppressed, FSM -> IDLE.

## Test plan
- Reset: assert `rst=0` mid-FETCH with `mem_req=1` -> `mem_req` drops same cycle, state IDLE, no ack after release until new request.
- Lone fetch: `if_req=1`, `if_addr=0x0000_0006`, memory acks 1 cycle after `mem_req` with `0xDEAD_BEEF` -> `mem_addr=0x0000_0004`, `if_ack=1`, `if_rdata=0xDEAD_BEEF`, `if_stall` high until ack.
- Contention: `if_req` and `d_req` (load, `0x100`) both high in IDLE -> DATA granted first, `if_stall=1` throughout, fetch granted after `d_ack`.
- Starvation bound: `if_req` and `d_req` held high continuously, `MAX_D_BURST=3` -> grant sequence D,D,D,F,D,D,D,F.
- Branch flush: FETCH of `0x40` in flight, `ex_take_branch_out` pulsed 2 cycles before `mem_ack` -> no `if_ack`; next request `0x80` fetched and acked normally.
- Store: `d_req=1`, `d_we=1`, `d_addr=0x200`, `d_wdata=0x1234_5678`, 3-cycle memory latency -> `mem_we=1`, `mem_wdata=0x1234_5678`, stable 3 cycles, `d_ack` one cycle, `d_stall` low afterward.
